// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx                                                      |
// | Description : 8N1-style asynchronous serial receiver, mid-bit sampling.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_idx_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_cnt_w-1:0] c_mid      = c_cnt_w'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    logic w_cnt_mid;
    logic w_cnt_end;
    logic w_good;
    logic w_bad;

    assign w_cnt_mid = (r_cnt == c_mid);
    assign w_cnt_end = (r_cnt == c_cnt_last);
    assign busy      = (r_state != c_st_idle);

    // Synchronizer resets to the idle level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!r_rx_s) w_state_nxt = c_st_start;
            end
            c_st_start: begin
                if (w_cnt_mid) w_state_nxt = r_rx_s ? c_st_idle : c_st_data;
            end
            c_st_data: begin
                if (w_cnt_end && (r_bit_idx == c_idx_last)) w_state_nxt = c_st_stop;
            end
            c_st_stop: begin
                if (w_cnt_end) begin
                    w_good      = r_rx_s;
                    w_bad       = !r_rx_s;
                    w_state_nxt = r_rx_s ? c_st_idle : c_st_break;
                end
            end
            c_st_break: begin
                if (r_rx_s) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // After the start mid-point the counter is re-zeroed, so every later wrap lands on a bit centre.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                c_st_start: begin
                    if (w_cnt_mid) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (w_cnt_end) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    r_cnt <= w_cnt_end ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= w_good;
            frame_err <= w_bad;
            if (w_good) data_out <= r_shift;
        end
    end

endmodule
`default_nettype wire
